// File: rtl/fetch_unit.sv
// Instruction fetch stage: issues word fetches, buffers one instruction for decode, handles redirects.
// Optional FETCH_ILLEGAL_HALT_EN: halt fetching and raise sticky illegal_o on an unsupported opcode.
module fetch_unit #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
  input  logic        clk_i,
  input  logic        rst_n_i,
  output logic        imem_req_o,
  output logic [31:0] imem_addr_o,
  input  logic        imem_ack_i,
  input  logic [31:0] imem_data_i,
  input  logic        redirect_i,
  input  logic [31:0] redirect_pc_i,
  input  logic        ready_i,
  output logic        valid_o,
  output logic [31:0] instr_o,
  output logic [5:0]  opcode_o,
  output logic [31:0] pc4_o,
  output logic        illegal_o
);

  localparam int unsigned PC_W  = 32;
  localparam int unsigned OP_W  = 6;
  localparam int unsigned OP_LO = 26;

  typedef enum logic [1:0] {
    BOOT = 2'd0,
    RUN  = 2'd1,
    HALT = 2'd2
  } state_t;

  state_t          state;
  state_t          state_next;
  logic [PC_W-1:0] pc;
  logic [PC_W-1:0] pc_plus4;
  logic            fire;
  logic            xfer;
  logic            halt_req;

  assign pc_plus4    = pc + PC_W'(4);
  assign imem_addr_o = pc;
  assign opcode_o    = instr_o[PC_W-1:OP_LO];

  // Request only when the buffer has (or is freeing) room; a redirect cancels the cycle's fetch.
  assign imem_req_o = (state == RUN) & (~valid_o | ready_i) & ~redirect_i;
  assign fire       = imem_req_o & imem_ack_i;
  assign xfer       = valid_o & ready_i;

`ifdef FETCH_ILLEGAL_HALT_EN
  function automatic logic op_supported(input logic [OP_W-1:0] op);
    case (op)
      6'b000000, 6'b100011, 6'b101011, 6'b000100: op_supported = 1'b1;
      default:                                    op_supported = 1'b0;
    endcase
  endfunction

  logic illegal;

  assign halt_req  = fire & ~op_supported(imem_data_i[PC_W-1:OP_LO]);
  assign illegal_o = illegal;

  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      illegal <= 1'b0;
    end else if (redirect_i) begin
      illegal <= 1'b0;
    end else if (halt_req) begin
      illegal <= 1'b1;
    end
  end
`else
  assign halt_req  = 1'b0;
  assign illegal_o = 1'b0;
`endif

  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      state <= BOOT;
    end else begin
      state <= state_next;
    end
  end

  always_comb begin
    state_next = state;
    case (state)
      BOOT:    state_next = RUN;
      RUN:     if (halt_req) state_next = HALT;
      HALT:    state_next = HALT;
      default: state_next = BOOT;
    endcase
    if (redirect_i) state_next = RUN;
  end

  // Single-entry buffer: redirect flushes, fetch refills (even while draining), transfer empties.
  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      pc      <= {RESET_PC[PC_W-1:2], 2'b00};
      valid_o <= 1'b0;
      instr_o <= '0;
      pc4_o   <= '0;
    end else if (redirect_i) begin
      pc      <= {redirect_pc_i[PC_W-1:2], 2'b00};
      valid_o <= 1'b0;
    end else if (fire) begin
      instr_o <= imem_data_i;
      pc4_o   <= pc_plus4;
      pc      <= pc_plus4;
      valid_o <= 1'b1;
    end else if (xfer) begin
      valid_o <= 1'b0;
    end
  end

endmodule

// File: tb/tb_fetch_unit.sv
// Bench for fetch_unit: directed scenarios, then randomized traffic against a reference model with a scoreboard.
module tb_fetch_unit;

  localparam logic [31:0] RST_PC = 32'h0000_0100;
  localparam int BOOT_S = 0;
  localparam int RUN_S  = 1;
  localparam int HALT_S = 2;

  logic        clk;
  logic        rst_n;
  logic        req;
  logic [31:0] addr;
  logic        ack;
  logic [31:0] data;
  logic        redirect;
  logic [31:0] rpc;
  logic        ready;
  logic        valid;
  logic [31:0] instr;
  logic [5:0]  opcode;
  logic [31:0] pc4;
  logic        illegal;

  typedef struct {
    logic [31:0] instr;
    logic [31:0] pc4;
  } exp_t;

  exp_t sb[$];
  int   total = 0;
  int   bad   = 0;
  bit   mon_en = 0;

  // reference model state
  int          m_state;
  logic [31:0] m_pc;
  bit          m_valid;
  bit          m_illegal;

  fetch_unit #(.RESET_PC(RST_PC)) dut (
    .clk_i        (clk),
    .rst_n_i      (rst_n),
    .imem_req_o   (req),
    .imem_addr_o  (addr),
    .imem_ack_i   (ack),
    .imem_data_i  (data),
    .redirect_i   (redirect),
    .redirect_pc_i(rpc),
    .ready_i      (ready),
    .valid_o      (valid),
    .instr_o      (instr),
    .opcode_o     (opcode),
    .pc4_o        (pc4),
    .illegal_o    (illegal)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
    end
  endtask

  function automatic logic [31:0] dword(input int k);
    return 32'h0000_1000 + 32'(k);
  endfunction

  function automatic bit supported(input logic [5:0] op);
    return op inside {6'b000000, 6'b100011, 6'b101011, 6'b000100};
  endfunction

  function automatic logic [31:0] rand_instr();
    logic [5:0] ops [4];
    logic [5:0] op;
    int r;
    ops[0] = 6'b000000; ops[1] = 6'b100011; ops[2] = 6'b101011; ops[3] = 6'b000100;
    r = $urandom_range(0, 15);
    op = (r < 14) ? ops[r % 4] : 6'($urandom);
    return {op, 26'($urandom)};
  endfunction

  // Spec-level model of one clock edge, using the inputs held during the cycle that just ended.
  task automatic model_step();
    bit fetch_ok;
    fetch_ok = (m_state == RUN_S) && (!m_valid || ready) && !redirect && ack;
    if (redirect) begin
      m_pc      = rpc & ~32'd3;
      m_valid   = 0;
      m_illegal = 0;
      m_state   = RUN_S;
      sb.delete();
    end else begin
      if (m_state == BOOT_S) m_state = RUN_S;
      if (fetch_ok) begin
        sb.push_back('{instr: data, pc4: m_pc + 32'd4});
        m_pc    = m_pc + 32'd4;
        m_valid = 1;
`ifdef FETCH_ILLEGAL_HALT_EN
        if (!supported(data[31:26])) begin
          m_illegal = 1;
          m_state   = HALT_S;
        end
`endif
      end else if (m_valid && ready) begin
        m_valid = 0;
      end
    end
  endtask

  // Monitor: every decode transfer must deliver the oldest outstanding fetched instruction.
  always @(negedge clk) begin
    if (mon_en && rst_n && valid && ready) begin
      if (sb.size() == 0) begin
        total++;
        bad++;
        $display("FAIL sb_empty: got transfer instr=%h with no expected entry at %0t", instr, $time);
      end else begin
        exp_t e;
        e = sb.pop_front();
        chk("sb_instr", instr, e.instr);
        chk("sb_pc4", pc4, e.pc4);
        chk("sb_opcode", 32'(opcode), 32'(e.instr[31:26]));
      end
    end
  end

  initial begin
    rst_n = 0; ack = 1; ready = 1; redirect = 0; rpc = '0; data = '0;
    #12;
    chk("rst_valid", valid, 0);
    chk("rst_req", req, 0);
    chk("rst_addr", addr, RST_PC);
    chk("rst_instr", instr, 0);
    chk("rst_pc4", pc4, 0);
    chk("rst_illegal", illegal, 0);

    @(negedge clk); rst_n = 1; #1;
    chk("boot_req", req, 0);

    for (int k = 0; k < 3; k++) begin
      @(posedge clk); #1; data = dword(k);
      @(negedge clk);
      chk("stream_req", req, 1);
      chk("stream_addr", addr, RST_PC + 32'(4 * k));
      if (k > 0) begin
        chk("stream_valid", valid, 1);
        chk("stream_pc4", pc4, RST_PC + 32'(4 * k));
        chk("stream_instr", instr, dword(k - 1));
      end
    end

    for (int i = 0; i < 5; i++) begin
      @(posedge clk); #1; ready = 0;
      @(negedge clk);
      chk("stall_req", req, 0);
      chk("stall_valid", valid, 1);
      chk("stall_instr", instr, dword(2));
      chk("stall_pc4", pc4, 32'h10C);
    end
    @(posedge clk); #1; ready = 1; data = dword(3);
    @(negedge clk);
    chk("unstall_req", req, 1);
    chk("unstall_addr", addr, 32'h10C);

    @(posedge clk); #1; redirect = 1; rpc = 32'h2003; data = 32'hDEAD_BEEF;
    @(negedge clk);
    chk("redir_req", req, 0);
    chk("redir_instr", instr, dword(3));
    @(posedge clk); #1; redirect = 0; data = dword(4);
    @(negedge clk);
    chk("redir_valid", valid, 0);
    chk("redir_addr", addr, 32'h2000);
    chk("redir_req2", req, 1);

    @(posedge clk); #1; redirect = 1; rpc = 32'hFFFF_FFFC;
    @(negedge clk);
    chk("redir_fetch_instr", instr, dword(4));
    chk("redir_fetch_pc4", pc4, 32'h2004);
    @(posedge clk); #1; redirect = 0; data = dword(5);
    @(negedge clk);
    chk("wrap_addr", addr, 32'hFFFF_FFFC);
    @(posedge clk); #1; data = 32'hFC00_0000;
    @(negedge clk);
    chk("wrap_pc4", pc4, 32'h0);
    chk("wrap_instr", instr, dword(5));
    chk("wrap_addr2", addr, 32'h0);
    chk("wrap_req", req, 1);

    @(posedge clk); #1; data = dword(6);
    @(negedge clk);
    chk("ill_valid", valid, 1);
    chk("ill_opcode", 32'(opcode), 32'h3F);
`ifdef FETCH_ILLEGAL_HALT_EN
    chk("ill_flag", illegal, 1);
    chk("halt_req", req, 0);
    for (int i = 1; i < 10; i++) begin
      @(posedge clk); #1;
      @(negedge clk);
      chk("halt_req", req, 0);
      chk("halt_flag", illegal, 1);
    end
`else
    chk("ill_flag", illegal, 0);
    chk("noill_req", req, 1);
    chk("noill_addr", addr, 32'h4);
    @(posedge clk); #1; data = dword(7);
    @(negedge clk);
    chk("noill_instr", instr, dword(6));
    chk("noill_pc4", pc4, 32'h8);
`endif
    @(posedge clk); #1; redirect = 1; rpc = 32'h80;
    @(posedge clk); #1; redirect = 0; data = dword(7);
    @(negedge clk);
    chk("recover_flag", illegal, 0);
    chk("recover_addr", addr, 32'h80);
    chk("recover_req", req, 1);
    @(posedge clk); #1; data = dword(8);
    @(negedge clk);
    chk("recover_instr", instr, dword(7));
    chk("recover_pc4", pc4, 32'h84);

    @(posedge clk); #3; rst_n = 0; #1;
    chk("arst_valid", valid, 0);
    chk("arst_req", req, 0);
    chk("arst_addr", addr, RST_PC);
    @(negedge clk); rst_n = 1; #1;
    chk("arst_boot_req", req, 0);
    @(posedge clk); #1;
    @(negedge clk);
    chk("arst_resume_req", req, 1);
    chk("arst_resume_addr", addr, RST_PC);

    // Randomized phase
    @(negedge clk); rst_n = 0; redirect = 0; ack = 1; ready = 1;
    @(negedge clk); rst_n = 1;
    m_state = BOOT_S; m_pc = RST_PC; m_valid = 0; m_illegal = 0;
    sb.delete();
    mon_en = 1;
    for (int i = 0; i < 3000; i++) begin
      @(posedge clk);
      model_step();
      #1;
      ack      = ($urandom_range(0, 3) != 0);
      ready    = ($urandom_range(0, 3) != 0);
      redirect = ($urandom_range(0, 19) == 0);
      rpc      = ($urandom_range(0, 3) == 0) ? (32'hFFFF_FFFC | ($urandom & 32'd3)) : $urandom;
      data     = rand_instr();
      @(negedge clk);
      chk("rnd_req", req, 32'((m_state == RUN_S) && (!m_valid || ready) && !redirect));
      chk("rnd_addr", addr, m_pc);
      chk("rnd_valid", valid, 32'(m_valid));
      chk("rnd_illegal", illegal, 32'(m_illegal));
    end
    mon_en = 0;

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
